vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source feeding the pixel-generation side (text-mode renderer) of the VGA path.
//  Scans x/y over the full line/frame, flags the visible area with valid.
//  Produces hsync/vsync, delayed to match the renderer's r/g/b pipeline latency.
//  Also emits a start-of-frame pulse and a frame counter (blink/animation timebase).
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   hsync pulse width (pixels)
//  H_BP      48   horizontal back porch; H_TOTAL = sum = 800
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch; V_TOTAL = sum = 525
//  SYNC_NEG  1    1: syncs active-low; 0: active-high
//  PIPE_DLY  3    clk cycles hsync/vsync lag x/y/valid; legal range 1..8
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous reset, active low
//  x          out  10  horizontal counter, 0..H_TOTAL-1
//  y          out  10  vertical counter, 0..V_TOTAL-1
//  valid      out  1   1 when x<H_ACTIVE and y<V_ACTIVE
//  pix_en     out  1   pixel-advance strobe (x/y update on this cycle)
//  sof        out  1   one-clk pulse when x/y become (0,0)
//  frame_cnt  out  8   frames started since reset, wraps 255->0
//  hsync      out  1   horizontal sync, delayed PIPE_DLY clk
//  vsync      out  1   vertical sync, delayed PIPE_DLY clk
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - x=H_TOTAL-1, y=V_TOTAL-1, valid=0, sof=0, frame_cnt=0.
//    - hsync/vsync and the whole delay line at the inactive level (SYNC_NEG ? 1 : 0).
//  - Counters advance only on clk edges with pix_en=1. x,y,valid,sof are all registers.
//  - Pixel advance: x increments. At x=H_TOTAL-1, x wraps to 0 and y increments.
//    At y=V_TOTAL-1 with x wrap, y also wraps to 0.
//  - First pix_en after reset release: x/y wrap to (0,0), valid=1, sof=1, frame_cnt=1.
//  - valid is registered from the next-state x/y, so it is aligned exactly with x/y.
//  - sof:
//    - High for exactly one clk, on the edge where x/y load (0,0).
//    - frame_cnt increments on that same edge.
//  - Raw sync, combinational from registered x/y:
//    - h active when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751).
//    - v active when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491).
//    - Polarity per SYNC_NEG.
//  - Sync delay line:
//    - Shift register of PIPE_DLY stages, shifts every clk regardless of pix_en.
//    - hsync/vsync at cycle t equal raw sync at t-PIPE_DLY.
//  - All comparisons are unsigned 10-bit. Parameters giving H_TOTAL or V_TOTAL > 1023 are illegal.
//  - Reset mid-frame: immediate return to reset values; the next frame restarts from (0,0) as above.
//  - No inputs other than clk/rst_n; there is no back-pressure. The consumer samples every clk.
// CONFIGURATION
//  - VGA_CLKDIV_EN defined:
//    - pix_en toggles every clk (toggle flop, reset 0), so the first pix_en comes 2nd clk after reset release.
//    - x/y hold for 2 clk; for 50 MHz clk -> 25 MHz pixel rate.
//  - VGA_CLKDIV_EN undefined: pix_en is constant 1 and x/y advance every clk.
//  - Sync delay is PIPE_DLY clk in both modes.
// TESTING
//  - Reset release, no CLKDIV -> 1st clk: x=0,y=0,valid=1,sof=1,frame_cnt=1; next clk: x=1,sof=0.
//  - Run 1 line -> valid falls when x becomes 640 and rises again when x wraps 799->0 with y=1.
//    Raw hsync is low for x=656..751 (96 clk).
//  - Run 1 frame -> vsync low exactly 2 lines (y=490..491), valid=0 for y>=480.
//    sof pulse every 420000 clk; frame_cnt=2.
//  - Hsync delay check -> hsync falls PIPE_DLY=3 clk after x becomes 656 (monitor x/y vs hsync).
//  - VGA_CLKDIV_EN -> pix_en alternates 0/1; each x value held 2 clk; frame length 840000 clk.
//  - Assert rst_n=0 at x=300,y=200 -> outputs go to reset values immediately, mid-cycle.
//    After release, clean frame starts at (0,0) with frame_cnt=1.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_timing_gen                                                |
// | Desc     : VGA raster timing source: x/y scan, visible-area valid,       |
// |            start-of-frame pulse, frame counter, and hsync/vsync delayed  |
// |            PIPE_DLY clk to line up with the renderer's r/g/b pipeline.   |
// |            Option macro VGA_CLKDIV_EN: pixel advance every second clk.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_NEG = 1'b1,
  parameter int PIPE_DLY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       valid,
  output logic       pix_en,
  output logic       sof,
  output logic [7:0] frame_cnt,
  output logic       hsync,
  output logic       vsync
);

  localparam logic [9:0] c_H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] c_V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] c_HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] c_VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       c_SYNC_IDLE = SYNC_NEG;

  logic [9:0]          w_x_nxt;
  logic [9:0]          w_y_nxt;
  logic                w_pix_en;
  logic                w_frame_start;
  logic                w_hs_raw;
  logic                w_vs_raw;
  logic [PIPE_DLY-1:0] r_hs_dly;
  logic [PIPE_DLY-1:0] r_vs_dly;

`ifdef VGA_CLKDIV_EN
  logic r_pix_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_en <= 1'b0;
    end else begin
      r_pix_en <= ~r_pix_en;
    end
  end

  assign w_pix_en = r_pix_en;
`else
  assign w_pix_en = 1'b1;
`endif

  assign pix_en = w_pix_en;

  always_comb begin
    w_x_nxt = x + 10'd1;
    w_y_nxt = y;
    if (x == c_H_LAST) begin
      w_x_nxt = '0;
      w_y_nxt = (y == c_V_LAST) ? '0 : y + 10'd1;
    end
  end

  assign w_frame_start = (w_x_nxt == '0) && (w_y_nxt == '0);

  // valid and sof come from next-state x/y so they stay aligned with x/y
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= c_H_LAST;
      y         <= c_V_LAST;
      valid     <= 1'b0;
      sof       <= 1'b0;
      frame_cnt <= '0;
    end else if (w_pix_en) begin
      x     <= w_x_nxt;
      y     <= w_y_nxt;
      valid <= (w_x_nxt < c_H_ACT) && (w_y_nxt < c_V_ACT);
      sof   <= w_frame_start;
      if (w_frame_start) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end else begin
      sof <= 1'b0;
    end
  end

  assign w_hs_raw = ((x >= c_HS_BEG) && (x < c_HS_END)) ? ~c_SYNC_IDLE : c_SYNC_IDLE;
  assign w_vs_raw = ((y >= c_VS_BEG) && (y < c_VS_END)) ? ~c_SYNC_IDLE : c_SYNC_IDLE;

  // Delay line runs every clk, independent of pix_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_dly <= {PIPE_DLY{c_SYNC_IDLE}};
      r_vs_dly <= {PIPE_DLY{c_SYNC_IDLE}};
    end else begin
      r_hs_dly[0] <= w_hs_raw;
      r_vs_dly[0] <= w_vs_raw;
      for (int i = 1; i < PIPE_DLY; i++) begin
        r_hs_dly[i] <= r_hs_dly[i-1];
        r_vs_dly[i] <= r_vs_dly[i-1];
      end
    end
  end

  assign hsync = r_hs_dly[PIPE_DLY-1];
  assign vsync = r_vs_dly[PIPE_DLY-1];

endmodule
`default_nettype wire
